// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC result widths and sample record
package adc_pkg;
  localparam int RESULT_BITS = 12;
  localparam int AVG_BITS    = 3;
  localparam int SEQ_BITS    = 4;

  typedef struct packed {
    logic [RESULT_BITS-1:0] result;
    logic [AVG_BITS-1:0]    avg;
    logic [SEQ_BITS-1:0]    seq;
  } adc_sample_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/adc_result_fifo_if.sv
// rtl/adc_result_fifo_if.sv - valid/ready head-of-FIFO result stream
interface adc_result_fifo_if;
  import adc_pkg::*;

  logic                   out_valid;
  logic                   out_ready;
  logic [RESULT_BITS-1:0] out_data;
  logic [AVG_BITS-1:0]    out_avg;
  logic [SEQ_BITS-1:0]    out_seq;

  modport master (output out_valid, output out_data, output out_avg, output out_seq,
                  input out_ready);
  modport slave  (input out_valid, input out_data, input out_avg, input out_seq,
                  output out_ready);
endinterface

// File: rtl/adc_result_fifo_mem.sv
// rtl/adc_result_fifo_mem.sv - sample storage, one write port, async read port
module adc_result_fifo_mem
  import adc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  adc_sample_t      wdata,
  input  logic [PTR_W-1:0] raddr,
  output adc_sample_t      rdata
);
  adc_sample_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/adc_result_fifo.sv
// rtl/adc_result_fifo.sv - captures SAR results on conv_finished edges into a tagged FWFT FIFO
module adc_result_fifo
  import adc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   conv_finished,
  input  logic [RESULT_BITS-1:0] result,
  input  logic [AVG_BITS-1:0]    avg_control,
  adc_result_fifo_if.master      out_if,
  output logic [CNT_W-1:0]       level,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic [7:0]             drop_count
);
  logic             cf_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic [SEQ_BITS-1:0] seq_q;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic        cap, full, empty, pop, wr_en, drop;
  adc_sample_t wr_sample, head;

  assign level = wr_cnt_q - rd_cnt_q;
  assign empty = (level == '0);
  assign full  = (level == CNT_W'(DEPTH));
  assign cap   = conv_finished & ~cf_q;
  assign pop   = ~empty & out_if.out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign wr_en = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  assign wr_sample = '{result: result, avg: avg_control, seq: seq_q};

  adc_result_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt_q[PTR_W-1:0]),
    .wdata (wr_sample),
    .raddr (rd_cnt_q[PTR_W-1:0]),
    .rdata (head)
  );

  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = empty ? '0 : head.result;
  assign out_if.out_avg   = empty ? '0 : head.avg;
  assign out_if.out_seq   = empty ? '0 : head.seq;
  assign overflow         = overflow_q;
  assign drop_count       = drop_q;

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_d     = sat_inc8(clear_overflow ? 8'd0 : drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cf_q       <= 1'b1;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      cf_q       <= conv_finished;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      if (wr_en) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (pop)   rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (cap)   seq_q    <= seq_q + SEQ_BITS'(1);
    end
  end
endmodule

// File: tb/tb_adc_result_fifo.sv
// tb/tb_adc_result_fifo.sv - directed self-checking bench for adc_result_fifo
module tb_adc_result_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        conv_finished;
  logic [11:0] result;
  logic [2:0]  avg_control;
  logic        clear_overflow;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  int tests = 0;
  int fails = 0;

  adc_result_fifo_if out_if();

  adc_result_fifo #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .conv_finished  (conv_finished),
    .result         (result),
    .avg_control    (avg_control),
    .out_if         (out_if),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; conv_finished = 1'b0; clear_overflow = 1'b0; out_if.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic capture(input logic [11:0] d, input logic [2:0] a);
    conv_finished = 1'b1; result = d; avg_control = a;
    tick();
    conv_finished = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; conv_finished = 1'b1; result = 12'd77; avg_control = 3'd5;
    clear_overflow = 1'b0; out_if.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tests++; if (out_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d exp 0", out_if.out_valid); end
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
    tests++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin fails++; $display("FAIL reset_ovf got %0d/%0d exp 0/0", overflow, drop_count); end
    tests++; if (out_if.out_data !== 12'd0 || out_if.out_seq !== 4'd0) begin fails++; $display("FAIL reset_head got %0d/%0d exp 0/0", out_if.out_data, out_if.out_seq); end
    conv_finished = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    conv_finished = 1'b1; result = 12'd1792; avg_control = 3'b001;
    tick();
    tests++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 12'd1792) begin fails++; $display("FAIL single_head got v%0d d%0d exp v1 d1792", out_if.out_valid, out_if.out_data); end
    tests++; if (out_if.out_avg !== 3'd1 || out_if.out_seq !== 4'd0 || level !== 4'd1) begin fails++; $display("FAIL single_tag got a%0d s%0d l%0d exp a1 s0 l1", out_if.out_avg, out_if.out_seq, level); end
    for (int i = 0; i < 5; i++) tick();
    tests++; if (level !== 4'd1) begin fails++; $display("FAIL single_hold_level got %0d exp 1", level); end
    conv_finished = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [11:0] vals [4];
    vals[0] = 12'd1024; vals[1] = 12'd13; vals[2] = 12'd515; vals[3] = 12'd4095;
    do_reset();
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      capture(vals[i], 3'(i));
      tests++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== vals[i] || out_if.out_seq !== 4'(i)) begin fails++; $display("FAIL stream_%0d got v%0d d%0d s%0d exp v1 d%0d s%0d", i, out_if.out_valid, out_if.out_data, out_if.out_seq, vals[i], i); end
      tick();
    end
    tests++; if (out_if.out_valid !== 1'b0) begin fails++; $display("FAIL stream_empty got %0d exp 0", out_if.out_valid); end
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin capture(12'(100 + i), 3'd2); tick(); end
    tests++; if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd1) begin fails++; $display("FAIL ovf_state got l%0d o%0d c%0d exp l8 o1 c1", level, overflow, drop_count); end
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (out_if.out_valid !== 1'b1 || out_if.out_seq !== 4'(i) || out_if.out_data !== 12'(100 + i)) begin fails++; $display("FAIL ovf_drain_%0d got v%0d s%0d d%0d exp v1 s%0d d%0d", i, out_if.out_valid, out_if.out_seq, out_if.out_data, i, 100 + i); end
      tick();
    end
    tests++; if (out_if.out_valid !== 1'b0) begin fails++; $display("FAIL ovf_after_drain got %0d exp 0", out_if.out_valid); end
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) begin capture(12'(200 + i), 3'd3); tick(); end
    out_if.out_ready = 1'b1;
    capture(12'd999, 3'd7);
    out_if.out_ready = 1'b0;
    tests++; if (level !== 4'd8 || overflow !== 1'b0 || drop_count !== 8'd0) begin fails++; $display("FAIL fullpop_state got l%0d o%0d c%0d exp l8 o0 c0", level, overflow, drop_count); end
    tests++; if (out_if.out_seq !== 4'd1 || out_if.out_data !== 12'd201) begin fails++; $display("FAIL fullpop_head got s%0d d%0d exp s1 d201", out_if.out_seq, out_if.out_data); end
    tick();
    capture(12'd1, 3'd0); tick();
    capture(12'd2, 3'd0); tick();
    tests++; if (drop_count !== 8'd2 || overflow !== 1'b1) begin fails++; $display("FAIL drops_two got c%0d o%0d exp c2 o1", drop_count, overflow); end
    clear_overflow = 1'b1;
    capture(12'd3, 3'd0);
    clear_overflow = 1'b0;
    tests++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin fails++; $display("FAIL clear_vs_drop got o%0d c%0d exp o1 c1", overflow, drop_count); end
    tick();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    tests++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin fails++; $display("FAIL clear_only got o%0d c%0d exp o0 c0", overflow, drop_count); end
    out_if.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tests++; if (out_if.out_seq !== 4'(i) || out_if.out_data !== 12'(200 + i)) begin fails++; $display("FAIL fullpop_drain_%0d got s%0d d%0d exp s%0d d%0d", i, out_if.out_seq, out_if.out_data, i, 200 + i); end
      tick();
    end
    tests++; if (out_if.out_valid !== 1'b1 || out_if.out_seq !== 4'd8 || out_if.out_data !== 12'd999 || out_if.out_avg !== 3'd7) begin fails++; $display("FAIL fullpop_last got v%0d s%0d d%0d a%0d exp v1 s8 d999 a7", out_if.out_valid, out_if.out_seq, out_if.out_data, out_if.out_avg); end
    tick();
    tests++; if (out_if.out_valid !== 1'b0) begin fails++; $display("FAIL fullpop_empty got %0d exp 0", out_if.out_valid); end
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      capture(12'(i * 37 + 5), 3'(i % 8));
      if (out_if.out_valid !== 1'b1 || out_if.out_seq !== 4'(i % 16) || out_if.out_data !== 12'(i * 37 + 5) || level !== 4'd1) begin
        errs++;
        $display("FAIL wrap_%0d got v%0d s%0d d%0d l%0d exp v1 s%0d d%0d l1", i, out_if.out_valid, out_if.out_seq, out_if.out_data, level, i % 16, i * 37 + 5);
      end
      out_if.out_ready = 1'b1;
      tick();
      out_if.out_ready = 1'b0;
      if (level !== 4'd0) begin errs++; $display("FAIL wrap_pop_%0d got l%0d exp l0", i, level); end
    end
    tests++; if (errs != 0) fails++;
    capture(12'd50, 3'd1); tick();
    capture(12'd51, 3'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (out_if.out_valid !== 1'b0 || level !== 4'd0) begin fails++; $display("FAIL midreset got v%0d l%0d exp v0 l0", out_if.out_valid, level); end
    tick();
    capture(12'd60, 3'd4);
    tests++; if (out_if.out_valid !== 1'b1 || out_if.out_seq !== 4'd0 || out_if.out_data !== 12'd60) begin fails++; $display("FAIL midreset_seq got v%0d s%0d d%0d exp v1 s0 d60", out_if.out_valid, out_if.out_seq, out_if.out_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_overflow();
    test_full_pop();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
